// File: rtl/int_ctrl.sv
//------------------------------------------------------------------------------
// int_ctrl
// Interrupt controller between NSRC edge-triggered device lines and a CPU
// exposing HWInt[7:2]. Latches rising edges into PEND, arbitrates among
// unmasked pending sources and runs a REQ/SERVICE handshake with the CPU
// (ack = interrupt taken, eoi = handler finished). No nesting.
//
// Optional feature: define INT_CTRL_RR_PRIO_EN for round-robin selection
// (search starts at rr_ptr). Default build uses fixed priority, index 0
// highest.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous, active-low reset
//   dev_irq  in   device request lines, rising-edge triggered
//   ack      in   one-cycle pulse, CPU took the interrupt
//   eoi      in   one-cycle pulse, handler finished
//   we       in   bridge write strobe
//   addr     in   bridge word select: 0 MASK, 1 PEND (W1C), 2 STATUS, 3 SWSET
//   wd       in   bridge write data
//   rd       out  bridge read data, combinational from addr
//   HWInt    out  registered one-hot request to the CPU
//   irq_id   out  registered index being requested/serviced, 7 when none
//
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module int_ctrl #(
    parameter int NSRC = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] dev_irq,
    input  logic            ack,
    input  logic            eoi,
    input  logic            we,
    input  logic [1:0]      addr,
    input  logic [31:0]     wd,
    output logic [31:0]     rd,
    output logic [NSRC-1:0] HWInt,
    output logic [2:0]      irq_id
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;
    localparam logic [2:0] NO_IRQ  = 3'd7;

    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] prev;
    logic [1:0]      state;
    // Low for the first edge after reset so a line already high at reset
    // release is absorbed into prev instead of being seen as an edge.
    logic            edge_en;
`ifdef INT_CTRL_RR_PRIO_EN
    logic [2:0]      rr_ptr;
`endif

    logic [NSRC-1:0] req;
    logic [NSRC-1:0] edges;
    logic [NSRC-1:0] pend_clr;
    logic [NSRC-1:0] pend_sw;
    logic [NSRC-1:0] pend_next;
    logic [NSRC-1:0] win_oh;
    logic [NSRC-1:0] cur_oh;
    logic [2:0]      win_id;
    logic            ack_take;
    logic            cur_live;
    logic            unused_wd;

    assign unused_wd = ^wd[31:NSRC];

    assign req      = pend & mask;
    assign edges    = dev_irq & ~prev & {NSRC{edge_en}};
    assign pend_clr = (we && addr == 2'd1) ? wd[NSRC-1:0] : '0;
    assign pend_sw  = (we && addr == 2'd3) ? wd[NSRC-1:0] : '0;
    assign ack_take = (state == REQ) && ack;

    // A new edge (or software set) always wins over a clear in the same cycle.
    assign pend_next = (pend & ~pend_clr & ~(ack_take ? cur_oh : '0)) | edges | pend_sw;

    // Winner select: iterate from lowest priority to highest so the last hit
    // assigned is the winner.
    always_comb begin
        win_id = NO_IRQ;
`ifdef INT_CTRL_RR_PRIO_EN
        begin
            int         k;
            logic [2:0] idx;
            k   = 0;
            idx = 3'd0;
            for (int i = NSRC - 1; i >= 0; i--) begin
                k = int'(rr_ptr) + i;
                if (k >= NSRC) k = k - NSRC;
                idx = 3'(k);
                if (req[idx]) win_id = idx;
            end
        end
`else
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) win_id = 3'(i);
        end
`endif
    end

    always_comb begin
        win_oh = '0;
        cur_oh = '0;
        for (int i = 0; i < NSRC; i++) begin
            win_oh[i] = (win_id == 3'(i));
            cur_oh[i] = (irq_id == 3'(i));
        end
    end

    // Request stays valid only while the selected source is pending and unmasked.
    assign cur_live = |(pend & mask & cur_oh);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask    <= '0;
            pend    <= '0;
            prev    <= '0;
            state   <= IDLE;
            HWInt   <= '0;
            irq_id  <= NO_IRQ;
            edge_en <= 1'b0;
`ifdef INT_CTRL_RR_PRIO_EN
            rr_ptr  <= 3'd0;
`endif
        end else begin
            prev    <= dev_irq;
            edge_en <= 1'b1;
            pend    <= pend_next;
            if (we && addr == 2'd0) mask <= wd[NSRC-1:0];

            case (state)
                IDLE: begin
                    if (|req) begin
                        state  <= REQ;
                        irq_id <= win_id;
                        HWInt  <= win_oh;
                    end
                end
                REQ: begin
                    if (ack) begin
                        state <= SERVICE;
                        HWInt <= '0;
`ifdef INT_CTRL_RR_PRIO_EN
                        rr_ptr <= (irq_id == 3'(NSRC - 1)) ? 3'd0 : irq_id + 3'd1;
`endif
                    end else if (!cur_live) begin
                        state  <= IDLE;
                        HWInt  <= '0;
                        irq_id <= NO_IRQ;
                    end
                end
                SERVICE: begin
                    if (eoi) begin
                        state  <= IDLE;
                        irq_id <= NO_IRQ;
                    end
                end
                default: begin
                    state  <= IDLE;
                    HWInt  <= '0;
                    irq_id <= NO_IRQ;
                end
            endcase
        end
    end

    always_comb begin
        rd = 32'd0;
        case (addr)
            2'd0:    rd = {{(32 - NSRC){1'b0}}, mask};
            2'd1:    rd = {{(32 - NSRC){1'b0}}, pend};
            2'd2:    rd = {27'd0, irq_id, state};
            default: rd = 32'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_int_ctrl.sv
//------------------------------------------------------------------------------
// tb_int_ctrl
// Directed self-checking bench for int_ctrl. Expected values are hand-derived;
// round-robin expectations apply when INT_CTRL_RR_PRIO_EN is defined.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  dev_irq;
    logic        ack;
    logic        eoi;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [5:0]  HWInt;
    logic [2:0]  irq_id;

    int n_checks = 0;
    int n_fail   = 0;

    int_ctrl #(.NSRC(6)) dut (
        .clk     (clk),
        .reset   (reset),
        .dev_irq (dev_irq),
        .ack     (ack),
        .eoi     (eoi),
        .we      (we),
        .addr    (addr),
        .wd      (wd),
        .rd      (rd),
        .HWInt   (HWInt),
        .irq_id  (irq_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        we   = 1'b1;
        addr = a;
        wd   = d;
        tick();
        we   = 1'b0;
        wd   = 32'd0;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, rd, exp);
    endtask

    logic [2:0] exp_a;
    logic [2:0] exp_b;
    logic [2:0] exp_g;

    initial begin
        reset   = 1'b0;
        dev_irq = '0;
        ack     = 1'b0;
        eoi     = 1'b0;
        we      = 1'b0;
        addr    = 2'd0;
        wd      = 32'd0;
        repeat (3) tick();

        // Reset state
        check("rst_hwint", {26'd0, HWInt}, 32'h0);
        check("rst_irq_id", {29'd0, irq_id}, 32'h7);
        check_reg("rst_mask", 2'd0, 32'h0);
        check_reg("rst_status", 2'd2, 32'h1C);
        reset = 1'b1;
        tick();

        // Single source, full handshake
        wr(2'd0, 32'h3F);
        dev_irq = 6'h04;
        tick();
        check_reg("t1_pend", 2'd1, 32'h04);
        check("t1_hwint_early", {26'd0, HWInt}, 32'h0);
        tick();
        check("t1_hwint", {26'd0, HWInt}, 32'h04);
        check("t1_irq_id", {29'd0, irq_id}, 32'h2);
        check_reg("t1_status_req", 2'd2, 32'h09);
        ack = 1'b1; tick(); ack = 1'b0;
        check_reg("t1_pend_ack", 2'd1, 32'h0);
        check_reg("t1_status_svc", 2'd2, 32'h0A);
        check("t1_hwint_svc", {26'd0, HWInt}, 32'h0);
        eoi = 1'b1; tick(); eoi = 1'b0;
        check("t1_irq_id_idle", {29'd0, irq_id}, 32'h7);
        check_reg("t1_status_idle", 2'd2, 32'h1C);
        dev_irq = '0;

        // Two simultaneous sources
`ifdef INT_CTRL_RR_PRIO_EN
        exp_a = 3'd4; exp_b = 3'd1;
`else
        exp_a = 3'd1; exp_b = 3'd4;
`endif
        dev_irq = 6'h12;
        tick();
        tick();
        check("t2_first_id", {29'd0, irq_id}, {29'd0, exp_a});
        check("t2_first_hw", {26'd0, HWInt}, 32'h1 << exp_a);
        ack = 1'b1; tick(); ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
        check("t2_idle_hw", {26'd0, HWInt}, 32'h0);
        tick();
        check("t2_second_id", {29'd0, irq_id}, {29'd0, exp_b});
        check("t2_second_hw", {26'd0, HWInt}, 32'h1 << exp_b);
        ack = 1'b1; tick(); ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
        dev_irq = '0;

        // Withdrawal by masking, re-request on unmask
        dev_irq = 6'h08;
        tick();
        tick();
        check("t3_hw", {26'd0, HWInt}, 32'h08);
        wr(2'd0, 32'h37);
        tick();
        check("t3_withdraw_hw", {26'd0, HWInt}, 32'h0);
        check_reg("t3_withdraw_status", 2'd2, 32'h1C);
        check_reg("t3_pend_kept", 2'd1, 32'h08);
        wr(2'd0, 32'h3F);
        tick();
        check("t3_rereq_hw", {26'd0, HWInt}, 32'h08);
        check("t3_rereq_id", {29'd0, irq_id}, 32'h3);
        ack = 1'b1; tick(); ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
        dev_irq = '0;

        // Register map corners, W1C vs edge, SWSET
        wr(2'd0, 32'hFFFF_FFFF);
        check_reg("t4_mask_bits", 2'd0, 32'h3F);
        wr(2'd0, 32'h0);
        wr(2'd2, 32'hFFFF_FFFF);
        check_reg("t4_status_ro", 2'd2, 32'h1C);
        check_reg("t4_addr3_zero", 2'd3, 32'h0);
        dev_irq = 6'h01;
        tick();
        check_reg("t4_pend_set", 2'd1, 32'h01);
        dev_irq = 6'h00;
        tick();
        we = 1'b1; addr = 2'd1; wd = 32'h01; dev_irq = 6'h01;
        tick();
        we = 1'b0; wd = 32'd0;
        check_reg("t4_w1c_vs_edge", 2'd1, 32'h01);
        wr(2'd1, 32'h01);
        check_reg("t4_w1c", 2'd1, 32'h0);
        wr(2'd3, 32'h20);
        check_reg("t4_swset", 2'd1, 32'h20);
        wr(2'd1, 32'h20);
        dev_irq = '0;
        tick();

        // Asynchronous reset mid-SERVICE, level held across release
        wr(2'd0, 32'h3F);
        dev_irq = 6'h20;
        tick();
        tick();
        check("t5_req_id", {29'd0, irq_id}, 32'h5);
        ack = 1'b1; tick(); ack = 1'b0;
        check_reg("t5_status_svc", 2'd2, 32'h16);
        #3;
        reset = 1'b0;
        #1;
        check("t5_rst_hw", {26'd0, HWInt}, 32'h0);
        check("t5_rst_id", {29'd0, irq_id}, 32'h7);
        check_reg("t5_rst_mask", 2'd0, 32'h0);
        check_reg("t5_rst_pend", 2'd1, 32'h0);
        #1;
        reset = 1'b1;
        tick();
        tick();
        check_reg("t5_no_edge_held", 2'd1, 32'h0);
        dev_irq = '0;
        tick();
        dev_irq = 6'h20;
        tick();
        check_reg("t5_edge_after_fall", 2'd1, 32'h20);
        wr(2'd1, 32'h20);
        dev_irq = '0;

        // Continuous re-pending of sources 0 and 1
        wr(2'd0, 32'h03);
        wr(2'd3, 32'h03);
        for (int g = 0; g < 4; g++) begin
`ifdef INT_CTRL_RR_PRIO_EN
            exp_g = 3'(g % 2);
`else
            exp_g = 3'd0;
`endif
            tick();
            check($sformatf("t6_grant%0d_id", g), {29'd0, irq_id}, {29'd0, exp_g});
            check($sformatf("t6_grant%0d_hw", g), {26'd0, HWInt}, 32'h1 << exp_g);
            ack = 1'b1; tick(); ack = 1'b0;
            wr(2'd3, 32'h03);
            eoi = 1'b1; tick(); eoi = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have parameter NSRC, default 6, the number of device interrupt sources, mapped onto HWInt[7:2].
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port dev_irq  in  6  device interrupt request lines, rising-edge triggered.
REQ-005 SHALL have port ack  in  1  one-cycle pulse: CPU has taken the interrupt (EXL set).
REQ-006 SHALL have port eoi  in  1  one-cycle pulse: handler finished (eret retired).
REQ-007 SHALL have port we  in  1  bridge register write strobe.
REQ-008 SHALL have port addr  in  2  bridge register word select (byte address bits 3:2).
REQ-009 SHALL have port wd  in  32  bridge write data.
REQ-010 SHALL have port rd  out  32  bridge read data, combinational from addr.
REQ-011 SHALL have port HWInt  out  6  registered one-hot request to CPU, bit i = source i.
REQ-012 SHALL have port irq_id  out  3  registered index of the source being requested or serviced; 7 when none.

Function
REQ-013 SHALL keep registers MASK[5:0], PEND[5:0], PREV[5:0], state, irq_id, and rr_ptr[2:0].
REQ-014 SHALL set PEND[i] on a clk edge where dev_irq[i]=1 and PREV[i]=0; PREV <= dev_irq every cycle.
REQ-015 SHALL decode addr: 0 MASK (rw, bits 5:0); 1 PEND (read, write-1-to-clear); 2 STATUS (read-only: [1:0] state, [4:2] irq_id); 3 SWSET (write-1-sets PEND).
REQ-016 SHALL read unused bits as 0 and ignore writes to STATUS.
REQ-017 SHALL, when a W1C clear and an edge set hit the same PEND bit in the same cycle, leave the bit set.
REQ-018 SHALL have states IDLE, REQ, SERVICE.
REQ-019 SHALL, in IDLE with any PEND&MASK bit set, select the winner (lowest index wins), go to REQ, set irq_id to the winner, and drive HWInt one-hot for it on the same edge.
REQ-020 SHALL, in REQ on ack, clear PEND[irq_id], clear HWInt, and go to SERVICE, irq_id held.
REQ-021 SHALL, in REQ without ack, when PEND[irq_id] or MASK[irq_id] becomes 0, withdraw: clear HWInt, irq_id=7, return to IDLE.
REQ-022 SHALL, in SERVICE on eoi, set irq_id=7 and return to IDLE; no nesting; new edges only accumulate in PEND.
REQ-023 SHALL ignore ack outside REQ and eoi outside SERVICE.
REQ-024 SHALL, when dev_irq rises before edge k, set PEND at k and assert HWInt at k+1 (state IDLE, no contention).
REQ-025 SHALL not re-arbitrate while in REQ; a higher-priority arrival waits for the next IDLE.
REQ-026 SHALL give ack priority over withdrawal when both occur in the same cycle in REQ.

Reset
REQ-027 SHALL, while reset=0, immediately force MASK=0, PEND=0, PREV=0, rr_ptr=0, state=IDLE, HWInt=0, irq_id=7, irrespective of clk.
REQ-028 SHALL, after reset mid-REQ or mid-SERVICE, lose the interrupt; a dev_irq level held high across reset release creates no edge until it falls and rises again.

Configuration
REQ-029 SHALL, with macro INT_CTRL_RR_PRIO_EN defined, use round-robin selection: search starts at rr_ptr, wrapping 5->0; on ack rr_ptr <= irq_id+1 mod 6.
REQ-030 SHALL, without INT_CTRL_RR_PRIO_EN, use fixed priority (index 0 highest); rr_ptr is absent and STATUS is unchanged.

Verification
REQ-031 SHALL cover: MASK=0x3F, dev_irq[2] rises -> PEND=0x04 next edge, HWInt=0x04 and irq_id=2 one edge later; ack -> PEND=0, state SERVICE; eoi -> IDLE, irq_id=7.
REQ-032 SHALL cover: MASK=0x3F, dev_irq[4] and [1] rise together -> HWInt=0x02; ack, eoi -> HWInt=0x10 on the following IDLE cycle.
REQ-033 SHALL cover: in REQ for id 3, write MASK=0x37 -> HWInt=0, IDLE, PEND[3] still 1; write MASK=0x3F -> HWInt=0x08 again.
REQ-034 SHALL cover: W1C PEND=0x01 in the same cycle as a dev_irq[0] edge -> PEND[0]=1; SWSET write 0x20 -> PEND[5]=1.
REQ-035 SHALL cover: reset=0 asserted mid-SERVICE between edges -> HWInt=0, irq_id=7, MASK=0 without a clk edge.
REQ-036 SHALL cover, with INT_CTRL_RR_PRIO_EN: sources 0 and 1 re-pending continuously -> grants alternate 0,1,0,1; without the macro -> always 0.
